// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ wclk-domain producers.
// A grant lasts until the owner's last beat or MAXBURST beats. Every beat is throttled by wfull.

module fifo_wr_arb_lane #(
  parameter int DSIZE = 8
) (
  input  logic             gnt,
  input  logic             valid,
  input  logic [DSIZE-1:0] data,
  input  logic             en,
  output logic             ready,
  output logic [DSIZE-1:0] data_m
);
  assign ready  = gnt & valid & en;
  assign data_m = gnt ? data : '0;
endmodule

module fifo_wr_arbiter #(
  parameter int DSIZE    = 8,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAXBURST + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

  logic                       pick_vld;
  logic [PW-1:0]              pick_idx;
  logic [PW-1:0]              gidx;
  logic                       g_last;
  logic                       lane_en;
  logic [NREQ-1:0][DSIZE-1:0] lane_data;

  function automatic logic [PW-1:0] wrap_idx(input int v);
    return PW'((v >= NREQ) ? v - NREQ : v);
  endfunction

  // Gating with wrst_n keeps a beat from being written in the cycle reset is applied.
  assign busy    = (state_q == BUSY) & wrst_n;
  assign lane_en = busy & ~wfull;
  assign gnt     = gnt_q;
  assign winc    = |req_ready;
  assign g_last  = |(gnt_q & req_last);

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    fifo_wr_arb_lane #(.DSIZE(DSIZE)) u_lane (
      .gnt   (gnt_q[i]),
      .valid (req_valid[i]),
      .data  (req_data[i*DSIZE +: DSIZE]),
      .en    (lane_en),
      .ready (req_ready[i]),
      .data_m(lane_data[i])
    );
  end

  always_comb begin
    wdata = '0;
    for (int i = 0; i < NREQ; i++) wdata = wdata | lane_data[i];
  end

  // Scan from the farthest offset down so the valid requester closest to rr_ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_idx(int'(rr_ptr_q) + k)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_idx(int'(rr_ptr_q) + k);
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) if (gnt_q[i]) gidx = PW'(i);
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d      = NREQ'(1) << pick_idx;
          beat_cnt_d = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (winc) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
          if (g_last || beat_cnt_q == CW'(MAXBURST - 1)) begin
            state_d  = IDLE;
            gnt_d    = '0;
            rr_ptr_d = wrap_idx(int'(gidx) + 1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
endmodule
